// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts spike events and peak membrane state over a
// selectable window, and measures the most recent inter-spike interval.
module spike_rate_monitor #(
   parameter int BURST_ISI = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             spike,
   input  logic [7:0]       state,
   input  logic [1:0]       window_sel,
   output logic [CNT_W-1:0] rate,
   output logic             rate_valid,
   output logic [7:0]       peak,
   output logic [CNT_W-1:0] isi,
   output logic             isi_valid,
   output logic             burst
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_ISI);

   fsm_t             fsm_r, fsm_nxt_s;
   logic [11:0]      win_r;
   logic [1:0]       len_r;
   logic [CNT_W-1:0] cnt_r;
   logic [7:0]       pk_r;
   logic             prev_r;
   logic             armed_r;
   logic [CNT_W-1:0] isi_cnt_r;
   logic [CNT_W-1:0] rate_r, isi_r;
   logic [7:0]       peak_r;
   logic             rate_valid_r, isi_valid_r, burst_r;

   logic             run_s, ev_s, last_s, isi_upd_s, isi_valid_nxt_s;
   logic [1:0]       sel_eff_s;
   logic [CNT_W-1:0] cnt_inc_s, isi_nxt_s;
   logic [7:0]       pk_max_s;

   function automatic logic [11:0] win_last(input logic [1:0] sel);
      case (sel)
         2'd0:    win_last = 12'd63;
         2'd1:    win_last = 12'd255;
         2'd2:    win_last = 12'd1023;
         default: win_last = 12'd4095;
      endcase
   endfunction

   // FSM next-state: RUN exactly while ena is high
   always_comb begin
      fsm_nxt_s = fsm_r;
      case (fsm_r)
         IDLE: begin
            if (ena) fsm_nxt_s = RUN;
            else     fsm_nxt_s = IDLE;
         end
         RUN: begin
            if (ena) fsm_nxt_s = RUN;
            else     fsm_nxt_s = IDLE;
         end
         default: fsm_nxt_s = IDLE;
      endcase
   end

   // Datapath next values for window, count, peak and interval
   always_comb begin
      run_s     = (fsm_nxt_s == RUN);
      ev_s      = spike & ~prev_r;
      sel_eff_s = (win_r == 12'd0) ? window_sel : len_r;
      last_s    = (win_r == win_last(sel_eff_s));
      if (ev_s && (cnt_r != CNT_MAX)) cnt_inc_s = cnt_r + CNT_ONE;
      else                            cnt_inc_s = cnt_r;
      if (state > pk_r) pk_max_s = state;
      else              pk_max_s = pk_r;
      isi_upd_s       = run_s & ev_s & armed_r;
      isi_valid_nxt_s = isi_valid_r | isi_upd_s;
      if (isi_upd_s) isi_nxt_s = isi_cnt_r;
      else           isi_nxt_s = isi_r;
   end

   // FSM state and previous-spike register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_r  <= IDLE;
         prev_r <= 1'b0;
      end else begin
         fsm_r  <= fsm_nxt_s;
         prev_r <= spike;
      end
   end

   // Window accumulation; completed windows publish rate and peak
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_r        <= 12'd0;
         len_r        <= 2'd0;
         cnt_r        <= '0;
         pk_r         <= 8'd0;
         rate_r       <= '0;
         peak_r       <= 8'd0;
         rate_valid_r <= 1'b0;
      end else if (run_s) begin
         len_r <= sel_eff_s;
         if (last_s) begin
            win_r        <= 12'd0;
            cnt_r        <= '0;
            pk_r         <= 8'd0;
            rate_r       <= cnt_inc_s;
            peak_r       <= pk_max_s;
            rate_valid_r <= 1'b1;
         end else begin
            win_r        <= win_r + 12'd1;
            cnt_r        <= cnt_inc_s;
            pk_r         <= pk_max_s;
            rate_valid_r <= 1'b0;
         end
      end else begin
         win_r        <= 12'd0;
         cnt_r        <= '0;
         pk_r         <= 8'd0;
         rate_valid_r <= 1'b0;
      end
   end

   // Inter-spike interval: first event after entering RUN only arms
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_r     <= 1'b0;
         isi_cnt_r   <= '0;
         isi_r       <= '0;
         isi_valid_r <= 1'b0;
         burst_r     <= 1'b0;
      end else begin
         isi_r       <= isi_nxt_s;
         isi_valid_r <= isi_valid_nxt_s;
         burst_r     <= isi_valid_nxt_s && (isi_nxt_s <= BURST_LIM);
         if (run_s) begin
            if (ev_s) begin
               armed_r   <= 1'b1;
               isi_cnt_r <= CNT_ONE;
            end else if (isi_cnt_r != CNT_MAX) begin
               isi_cnt_r <= isi_cnt_r + CNT_ONE;
            end else begin
               isi_cnt_r <= isi_cnt_r;
            end
         end else begin
            armed_r   <= 1'b0;
            isi_cnt_r <= '0;
         end
      end
   end

   assign rate       = rate_r;
   assign rate_valid = rate_valid_r;
   assign peak       = peak_r;
   assign isi        = isi_r;
   assign isi_valid  = isi_valid_r;
   assign burst      = burst_r;

endmodule
